// File: rtl/bypass_scb.sv
// Operand delivery, forwarding and long-unit scoreboard between ID and EX.
// Owns the architectural register file and the stall performance counter.
module bypass_scb #(
    parameter int CPU_WIDTH = 64,
    parameter int REG_ADDRW = 5,
    parameter int NRP       = 2,
    parameter int CNTW      = 32,
    localparam int REG_COUNT = 2**REG_ADDRW
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_idu_valid,
    input  logic [NRP-1:0]           i_idu_rsen,
    input  logic [NRP*REG_ADDRW-1:0] i_idu_rsid,
    input  logic                     i_idu_rdwen,
    input  logic [REG_ADDRW-1:0]     i_idu_rdid,
    input  logic                     i_idu_lng,
    input  logic                     i_exu_lden,
    input  logic                     i_exu_rdwen,
    input  logic [REG_ADDRW-1:0]     i_exu_rdid,
    input  logic [CPU_WIDTH-1:0]     i_exu_exres,
    input  logic                     i_lsu_lden,
    input  logic                     i_lsu_rdwen,
    input  logic [REG_ADDRW-1:0]     i_lsu_rdid,
    input  logic [CPU_WIDTH-1:0]     i_lsu_exres,
    input  logic [CPU_WIDTH-1:0]     i_lsu_lsres,
    input  logic                     i_wbu_rdwen,
    input  logic [REG_ADDRW-1:0]     i_wbu_rdid,
    input  logic [CPU_WIDTH-1:0]     i_wbu_rd,
    input  logic                     i_lng_wen,
    input  logic [REG_ADDRW-1:0]     i_lng_rdid,
    input  logic [CPU_WIDTH-1:0]     i_lng_rd,
    input  logic                     i_lng_kill,
    output logic [NRP*CPU_WIDTH-1:0] o_idu_rs,
    output logic                     o_idex_nop,
    output logic                     o_ifid_stall,
    output logic                     o_lng_busy,
    output logic [CNTW-1:0]          o_stall_cnt,
    output logic                     s_a0zero,
    output logic [CPU_WIDTH-1:0]     s_regs [REG_COUNT]
);

    logic [CPU_WIDTH-1:0] r_regs [REG_COUNT];
    logic [REG_COUNT-1:0] r_busy;
    logic                 r_inflight;
    logic [CNTW-1:0]      r_stall_cnt;

    logic [REG_COUNT-1:0] w_busy_nxt;
    logic                 w_inflight_nxt;
    logic [NRP-1:0]       w_hzd;
    logic                 w_rd_nz;
    logic                 w_waw;
    logic                 w_struct;
    logic                 w_stall;
    logic                 w_issue;

    // Per read port: forwarding mux and hazard detect
    for (genvar k = 0; k < NRP; k++) begin : g_port
        logic [REG_ADDRW-1:0] w_id;
        logic [CPU_WIDTH-1:0] w_rs;
        logic                 w_use;
        logic                 w_ldu;
        logic                 w_raw;

        assign w_id = i_idu_rsid[k*REG_ADDRW +: REG_ADDRW];

        always_comb begin
            w_rs = r_regs[w_id];
            if (w_id == '0) begin
                w_rs = '0;
            end else if (i_lng_wen && i_lng_rdid == w_id) begin
                w_rs = i_lng_rd;
            end else if (i_exu_rdwen && !i_exu_lden && i_exu_rdid == w_id) begin
                w_rs = i_exu_exres;
            end else if (i_lsu_rdwen && i_lsu_rdid == w_id) begin
                w_rs = i_lsu_lden ? i_lsu_lsres : i_lsu_exres;
            end else if (i_wbu_rdwen && i_wbu_rdid == w_id) begin
                w_rs = i_wbu_rd;
            end
        end

        assign w_use = i_idu_rsen[k] && (w_id != '0);
        assign w_ldu = i_exu_lden && i_exu_rdwen && (i_exu_rdid == w_id);
        assign w_raw = r_busy[w_id] && !(i_lng_wen && i_lng_rdid == w_id);
        assign w_hzd[k] = w_use && (w_ldu || w_raw);
        assign o_idu_rs[k*CPU_WIDTH +: CPU_WIDTH] = w_rs;
    end

    assign w_rd_nz  = i_idu_rdwen && (i_idu_rdid != '0);
    assign w_waw    = w_rd_nz && r_busy[i_idu_rdid]
                    && !(i_lng_wen && i_lng_rdid == i_idu_rdid);
    assign w_struct = i_idu_lng && r_inflight && !i_lng_wen;
    assign w_stall  = i_idu_valid && ((|w_hzd) || w_waw || w_struct);
    assign w_issue  = i_idu_valid && !w_stall && i_idu_lng;

    // Release first, then issue set (set wins), kill overrides both
    always_comb begin
        w_busy_nxt     = r_busy;
        w_inflight_nxt = r_inflight;
        if (i_lng_wen) begin
            w_busy_nxt[i_lng_rdid] = 1'b0;
            w_inflight_nxt         = 1'b0;
        end
        if (w_issue) begin
            w_inflight_nxt = 1'b1;
            if (w_rd_nz) begin
                w_busy_nxt[i_idu_rdid] = 1'b1;
            end
        end
        if (i_lng_kill) begin
            w_busy_nxt     = '0;
            w_inflight_nxt = 1'b0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy      <= '0;
            r_inflight  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_inflight <= w_inflight_nxt;
            if (w_stall && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            end
        end
    end

    // Long-unit port is written last so it wins a same-rd collision
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (i_wbu_rdwen && i_wbu_rdid != '0) begin
                r_regs[i_wbu_rdid] <= i_wbu_rd;
            end
            if (i_lng_wen && i_lng_rdid != '0) begin
                r_regs[i_lng_rdid] <= i_lng_rd;
            end
        end
    end

    assign o_idex_nop   = w_stall;
    assign o_ifid_stall = w_stall;
    assign o_lng_busy   = r_inflight;
    assign o_stall_cnt  = r_stall_cnt;
    assign s_a0zero     = (r_regs[10] == '0);
    assign s_regs       = r_regs;

endmodule

// File: tb/tb_bypass_scb.sv
// Directed bench for bypass_scb: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_bypass_scb;

    localparam int CW  = 64;
    localparam int AW  = 5;
    localparam int NP  = 2;
    localparam int CNW = 4;

    localparam int S_RS0   = 0;
    localparam int S_RS1   = 1;
    localparam int S_STALL = 2;
    localparam int S_BUSY  = 3;
    localparam int S_CNT   = 4;
    localparam int S_REG   = 5;
    localparam int S_A0    = 6;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_idu_valid;
    logic [NP-1:0]   i_idu_rsen;
    logic [NP*AW-1:0] i_idu_rsid;
    logic            i_idu_rdwen;
    logic [AW-1:0]   i_idu_rdid;
    logic            i_idu_lng;
    logic            i_exu_lden;
    logic            i_exu_rdwen;
    logic [AW-1:0]   i_exu_rdid;
    logic [CW-1:0]   i_exu_exres;
    logic            i_lsu_lden;
    logic            i_lsu_rdwen;
    logic [AW-1:0]   i_lsu_rdid;
    logic [CW-1:0]   i_lsu_exres;
    logic [CW-1:0]   i_lsu_lsres;
    logic            i_wbu_rdwen;
    logic [AW-1:0]   i_wbu_rdid;
    logic [CW-1:0]   i_wbu_rd;
    logic            i_lng_wen;
    logic [AW-1:0]   i_lng_rdid;
    logic [CW-1:0]   i_lng_rd;
    logic            i_lng_kill;
    logic [NP*CW-1:0] o_idu_rs;
    logic            o_idex_nop;
    logic            o_ifid_stall;
    logic            o_lng_busy;
    logic [CNW-1:0]  o_stall_cnt;
    logic            s_a0zero;
    logic [CW-1:0]   s_regs [32];

    bypass_scb #(
        .CPU_WIDTH(CW), .REG_ADDRW(AW), .NRP(NP), .CNTW(CNW)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_idu_valid(i_idu_valid), .i_idu_rsen(i_idu_rsen),
        .i_idu_rsid(i_idu_rsid), .i_idu_rdwen(i_idu_rdwen),
        .i_idu_rdid(i_idu_rdid), .i_idu_lng(i_idu_lng),
        .i_exu_lden(i_exu_lden), .i_exu_rdwen(i_exu_rdwen),
        .i_exu_rdid(i_exu_rdid), .i_exu_exres(i_exu_exres),
        .i_lsu_lden(i_lsu_lden), .i_lsu_rdwen(i_lsu_rdwen),
        .i_lsu_rdid(i_lsu_rdid), .i_lsu_exres(i_lsu_exres),
        .i_lsu_lsres(i_lsu_lsres),
        .i_wbu_rdwen(i_wbu_rdwen), .i_wbu_rdid(i_wbu_rdid),
        .i_wbu_rd(i_wbu_rd),
        .i_lng_wen(i_lng_wen), .i_lng_rdid(i_lng_rdid),
        .i_lng_rd(i_lng_rd), .i_lng_kill(i_lng_kill),
        .o_idu_rs(o_idu_rs), .o_idex_nop(o_idex_nop),
        .o_ifid_stall(o_ifid_stall), .o_lng_busy(o_lng_busy),
        .o_stall_cnt(o_stall_cnt), .s_a0zero(s_a0zero),
        .s_regs(s_regs)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          sel;
        int          idx;
        logic [63:0] exp;
        string       nm;
    } chk_t;

    chk_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic ex(input int sel, input logic [63:0] v, input string nm,
                      input int idx = 0);
        chk_t c;
        c.sel = sel; c.idx = idx; c.exp = v; c.nm = nm;
        q.push_back(c);
    endtask

    function automatic logic [63:0] observe(input int sel, input int idx);
        case (sel)
            S_RS0:   return o_idu_rs[CW-1:0];
            S_RS1:   return o_idu_rs[2*CW-1:CW];
            S_STALL: return {62'd0, o_idex_nop, o_ifid_stall};
            S_BUSY:  return {63'd0, o_lng_busy};
            S_CNT:   return {60'd0, o_stall_cnt};
            S_REG:   return s_regs[idx];
            S_A0:    return {63'd0, s_a0zero};
            default: return 64'hdead;
        endcase
    endfunction

    chk_t        m_c;
    logic [63:0] m_act;
    always @(negedge i_clk) begin
        while (q.size() > 0) begin
            m_c   = q.pop_front();
            m_act = observe(m_c.sel, m_c.idx);
            checks++;
            if (m_act !== m_c.exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h",
                         m_c.nm, m_act, m_c.exp);
            end
        end
    end

    task automatic go();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_idu_valid = 0; i_idu_rsen = '0; i_idu_rsid = '0;
        i_idu_rdwen = 0; i_idu_rdid = '0; i_idu_lng = 0;
        i_exu_lden = 0; i_exu_rdwen = 0; i_exu_rdid = '0; i_exu_exres = '0;
        i_lsu_lden = 0; i_lsu_rdwen = 0; i_lsu_rdid = '0;
        i_lsu_exres = '0; i_lsu_lsres = '0;
        i_wbu_rdwen = 0; i_wbu_rdid = '0; i_wbu_rd = '0;
        i_lng_wen = 0; i_lng_rdid = '0; i_lng_rd = '0; i_lng_kill = 0;
    endtask

    task automatic issue_lng(input logic [AW-1:0] rd);
        idle();
        i_idu_valid = 1; i_idu_lng = 1; i_idu_rdwen = 1; i_idu_rdid = rd;
    endtask

    task automatic rd_ports(input logic [1:0] en, input logic [AW-1:0] r1,
                            input logic [AW-1:0] r0);
        idle();
        i_idu_valid = 1; i_idu_rsen = en; i_idu_rsid = {r1, r0};
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        i_rst = 1;
        go();
        ex(S_STALL, 0, "rst_stall");
        ex(S_CNT, 0, "rst_cnt");
        ex(S_BUSY, 0, "rst_busy");
        ex(S_REG, 0, "rst_x5", 5);
        ex(S_A0, 1, "rst_a0zero");
        go();
        i_rst = 0;

        // forwarding priority EX > LSU > WBU, load takes lsres
        rd_ports(2'b01, 5'd0, 5'd5);
        i_wbu_rdwen = 1; i_wbu_rdid = 5; i_wbu_rd = 1;
        i_lsu_rdwen = 1; i_lsu_rdid = 5; i_lsu_exres = 2;
        i_exu_rdwen = 1; i_exu_rdid = 5; i_exu_exres = 3;
        ex(S_RS0, 3, "fwd_ex");
        go();
        i_exu_rdwen = 0;
        ex(S_RS0, 2, "fwd_lsu");
        go();
        i_lsu_lden = 1; i_lsu_lsres = 7;
        ex(S_RS0, 7, "fwd_lsu_load");
        ex(S_STALL, 0, "fwd_nostall");
        go();
        idle();
        ex(S_REG, 1, "wb_x5", 5);

        // load-use on port 1
        go();
        rd_ports(2'b10, 5'd6, 5'd0);
        i_exu_lden = 1; i_exu_rdwen = 1; i_exu_rdid = 6;
        ex(S_STALL, 3, "lu_stall");
        go();
        i_idu_rsen = 2'b00;
        ex(S_STALL, 0, "lu_unused");
        ex(S_CNT, 1, "lu_cnt");
        go();
        idle();
        ex(S_CNT, 1, "lu_cnt_hold");

        // long RAW with cycle-exact release
        go();
        issue_lng(5'd8);
        ex(S_STALL, 0, "div8_issue");
        ex(S_BUSY, 0, "div8_pre");
        go();
        rd_ports(2'b01, 5'd0, 5'd8);
        ex(S_STALL, 3, "raw8_a");
        ex(S_BUSY, 1, "div8_busy");
        go();
        ex(S_STALL, 3, "raw8_b");
        go();
        i_lng_wen = 1; i_lng_rdid = 8; i_lng_rd = 64'h55;
        ex(S_STALL, 0, "raw8_release");
        ex(S_RS0, 64'h55, "raw8_fwd");
        go();
        i_lng_wen = 0;
        ex(S_STALL, 0, "raw8_after");
        ex(S_BUSY, 0, "div8_done");
        ex(S_RS0, 64'h55, "x8_regfile");
        ex(S_CNT, 3, "raw_cnt");

        // WAW, structural, back-to-back issue on release
        go();
        issue_lng(5'd9);
        ex(S_STALL, 0, "div9_issue");
        go();
        idle();
        i_idu_valid = 1; i_idu_rdwen = 1; i_idu_rdid = 9;
        ex(S_STALL, 3, "waw9");
        go();
        issue_lng(5'd4);
        ex(S_STALL, 3, "struct_mul4");
        go();
        i_lng_wen = 1; i_lng_rdid = 9; i_lng_rd = 64'h99;
        ex(S_STALL, 0, "mul4_b2b_issue");
        go();
        rd_ports(2'b11, 5'd9, 5'd4);
        ex(S_STALL, 3, "raw4");
        ex(S_BUSY, 1, "mul4_busy");
        ex(S_RS1, 64'h99, "x9_regfile");
        go();
        i_lng_wen = 1; i_lng_rdid = 4; i_lng_rd = 64'h44;
        ex(S_STALL, 0, "raw4_release");
        ex(S_RS0, 64'h44, "raw4_fwd");
        go();
        idle();
        ex(S_CNT, 6, "waw_cnt");
        ex(S_BUSY, 0, "mul4_done");

        // WBU/LNG same rd: LNG wins in both forward and regfile
        go();
        rd_ports(2'b01, 5'd0, 5'd3);
        i_wbu_rdwen = 1; i_wbu_rdid = 3; i_wbu_rd = 64'hA;
        i_lng_wen = 1; i_lng_rdid = 3; i_lng_rd = 64'hB;
        ex(S_RS0, 64'hB, "fwd_lng_pri");
        go();
        idle();
        i_wbu_rdwen = 1; i_wbu_rdid = 10; i_wbu_rd = 64'h5;
        ex(S_REG, 64'hB, "wr_conflict", 3);
        go();
        idle();
        ex(S_A0, 0, "a0_nonzero");

        // x0 target: inflight only, never forwarded
        go();
        issue_lng(5'd0);
        ex(S_STALL, 0, "x0_issue");
        go();
        rd_ports(2'b01, 5'd0, 5'd0);
        i_wbu_rdwen = 1; i_wbu_rdid = 0; i_wbu_rd = 64'hFF;
        i_exu_rdwen = 1; i_exu_rdid = 0; i_exu_exres = 64'h77;
        ex(S_BUSY, 1, "x0_inflight");
        ex(S_STALL, 0, "x0_nostall");
        ex(S_RS0, 0, "x0_read");
        go();
        rd_ports(2'b01, 5'd0, 5'd0);
        i_lng_wen = 1; i_lng_rdid = 0; i_lng_rd = 64'h33;
        ex(S_RS0, 0, "x0_lng_fwd");
        go();
        idle();
        ex(S_BUSY, 0, "x0_done");
        ex(S_REG, 0, "x0_reg", 0);

        // asynchronous reset mid long-op
        go();
        issue_lng(5'd8);
        ex(S_STALL, 0, "d8_issue");
        go();
        rd_ports(2'b01, 5'd0, 5'd8);
        ex(S_STALL, 3, "d8_raw");
        ex(S_CNT, 6, "pre_rst_cnt");
        go();
        i_rst = 1;
        ex(S_BUSY, 0, "arst_busy");
        ex(S_CNT, 0, "arst_cnt");
        ex(S_STALL, 0, "arst_stall");
        ex(S_REG, 0, "arst_x8", 8);
        ex(S_REG, 0, "arst_x3", 3);
        go();
        i_rst = 0;

        // kill: clears scoreboard next edge, counter kept
        issue_lng(5'd8);
        ex(S_STALL, 0, "k_issue");
        go();
        rd_ports(2'b01, 5'd0, 5'd8);
        i_lng_kill = 1;
        ex(S_STALL, 3, "k_stall");
        ex(S_BUSY, 1, "k_busy");
        go();
        i_lng_kill = 0;
        ex(S_STALL, 0, "k_clear");
        ex(S_BUSY, 0, "k_inflight");
        ex(S_CNT, 1, "k_cnt");

        // counter saturation under continuous load-use stall
        go();
        rd_ports(2'b01, 5'd0, 5'd6);
        i_exu_lden = 1; i_exu_rdwen = 1; i_exu_rdid = 6;
        for (int i = 0; i < 20; i++) begin
            ex(S_CNT, (i + 1 > 15) ? 15 : i + 1, "sat_cnt");
            ex(S_STALL, 3, "sat_stall");
            go();
        end
        idle();
        ex(S_CNT, 15, "sat_hold");

        go();
        @(negedge i_clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
